// File: rtl/uart_cmd_ctrl.sv
// Frame controller: turns SYNC/ADDR/DATA/CHK byte frames from the UART receiver into
// single-cycle register writes. Define UART_CMD_TIMEOUT_EN to add an inter-byte timeout.
module uart_cmd_ctrl #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC_BYTE   = WIDTH'(8'hA5),
  parameter int               TIMEOUT_CYC = 500000
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  input  logic             rx_error,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             frame_err,
  output logic [7:0]       err_cnt,
  output logic             busy
);

  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_CHK, S_WRITE} state_t;

  state_t           state;
  logic             rdy_q;
  logic             err_q;
  logic [WIDTH-1:0] addr_r;
  logic [WIDTH-1:0] data_r;
  logic             byte_evt;
  logic             err_evt;
  logic             tmo_evt;
  logic             in_frame;
  logic             abort;
  logic [WIDTH-1:0] chk;

  // Handshake: rx_ready/rx_error are receiver levels with no back-pressure; only their
  // rising edges count, so a held rx_ready is one byte and rx_data is taken on that edge.
  assign byte_evt = rx_ready & ~rdy_q;
  assign err_evt  = rx_error & ~err_q;
  assign in_frame = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign chk      = SYNC_BYTE ^ addr_r ^ data_r;
  // A byte arriving in the expiry cycle beats the timeout; a receiver error beats both.
  assign abort    = err_evt | (tmo_evt & ~byte_evt);
  assign busy     = (state != S_HUNT);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (byte_evt && (state != S_CHK)) begin
      tmo_cnt <= TW'(TIMEOUT_CYC - 1);
    end else if (in_frame && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end

  assign tmo_evt = in_frame && (tmo_cnt == '0);
`else
  assign tmo_evt = 1'b0;
`endif

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_r    <= '0;
      data_r    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      rdy_q     <= rx_ready;
      err_q     <= rx_error;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (in_frame && abort) begin
        frame_err <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        state <= S_HUNT;
      end else begin
        case (state)
          S_HUNT: begin
            if (byte_evt && (rx_data == SYNC_BYTE)) state <= S_ADDR;
          end
          S_ADDR: begin
            if (byte_evt) begin
              addr_r <= rx_data;
              state  <= S_DATA;
            end
          end
          S_DATA: begin
            if (byte_evt) begin
              data_r <= rx_data;
              state  <= S_CHK;
            end
          end
          S_CHK: begin
            if (byte_evt) begin
              if (rx_data == chk) begin
                state <= S_WRITE;
              end else begin
                frame_err <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                state <= S_HUNT;
              end
            end
          end
          S_WRITE: begin
            wr_en   <= 1'b1;
            wr_addr <= addr_r;
            wr_data <= data_r;
            // This cycle already behaves as HUNT for an incoming byte.
            state   <= (byte_evt && (rx_data == SYNC_BYTE)) ? S_ADDR : S_HUNT;
          end
          default: state <= S_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed plan cases plus randomized byte/error traffic
// checked against a byte-level frame model.
module tb_uart_cmd_ctrl;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 500000;
`endif

  logic       clk50m = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       busy;

  uart_cmd_ctrl #(.WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TMO)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_error(rx_error), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
  );

  // clock / reset
  always #10 clk50m = ~clk50m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: frame assembled as a byte list
  logic [7:0]  frm[$];
  logic [15:0] exp_q[$];
  int          exp_errs = 0;
  int          exp_pulses = 0;
  int          seen_pulses = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [7:0]  last_data = 8'h00;

  task automatic model_bad();
    exp_errs++;
    exp_pulses++;
    frm.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (frm.size() == 0) begin
      if (b == 8'hA5) frm.push_back(b);
    end else begin
      frm.push_back(b);
      if (frm.size() == 4) begin
        if ((8'hA5 ^ frm[1] ^ frm[2]) == frm[3]) begin
          exp_q.push_back({frm[1], frm[2]});
          last_addr = frm[1];
          last_data = frm[2];
          frm.delete();
        end else begin
          model_bad();
        end
      end
    end
  endtask

  task automatic model_err();
    if (frm.size() != 0) model_bad();
  endtask

  // scoreboard
  always @(negedge clk50m) begin
    if (frame_err) seen_pulses++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 1, 0);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[15:8]);
        check("wr_data", wr_data, e[7:0]);
      end
    end
  end

  // drivers
  task automatic tick(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    tick(1);
    rx_data  = b;
    rx_ready = 1'b1;
    model_byte(b);
    tick(hold);
    rx_ready = 1'b0;
    rx_data  = $urandom_range(0, 255);
    tick(2);
  endtask

  task automatic send_err();
    tick(1);
    rx_error = 1'b1;
    model_err();
    tick(2);
    rx_error = 1'b0;
    tick(2);
  endtask

  task automatic send_byte_err(input logic [7:0] b);
    tick(1);
    rx_data  = b;
    rx_ready = 1'b1;
    rx_error = 1'b1;
    if (frm.size() != 0) model_bad();
    else model_byte(b);
    tick(2);
    rx_ready = 1'b0;
    rx_error = 1'b0;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                            input int hold);
    send_byte(8'hA5, hold);
    send_byte(a, hold);
    send_byte(d, hold);
    send_byte(c, hold);
  endtask

  task automatic checkpoint(input string tag);
    repeat (6) @(negedge clk50m);
    check({tag, "_pending_wr"}, exp_q.size(), 0);
    check({tag, "_err_pulses"}, seen_pulses, exp_pulses);
    check({tag, "_err_cnt"}, err_cnt, (exp_errs > 255) ? 255 : exp_errs);
    check({tag, "_busy"}, busy, (frm.size() != 0) ? 1 : 0);
    check({tag, "_addr_hold"}, wr_addr, last_addr);
    check({tag, "_data_hold"}, wr_data, last_data);
  endtask

  task automatic apply_reset(input string tag);
    tick(1);
    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_error = 1'b0;
    frm.delete();
    exp_errs  = 0;
    last_addr = 8'h00;
    last_data = 8'h00;
    repeat (2) @(negedge clk50m);
    check({tag, "_rst_outputs"}, {wr_en, frame_err, busy, wr_addr, wr_data, err_cnt}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    logic [7:0] a, d, c;
    apply_reset("init");

    // valid frame
    send_frame(8'h12, 8'h34, 8'h83, 1);
    checkpoint("valid");
    // bad checksum
    send_frame(8'h12, 8'h34, 8'h00, 1);
    checkpoint("badchk");
    // garbage then frame
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_frame(8'h01, 8'h02, 8'hA6, 1);
    checkpoint("garbage");
    // held rx_ready
    send_frame(8'h05, 8'h06, 8'hA6, 20);
    checkpoint("held");
    // error during DATA, then simultaneous error/byte in ADDR
    send_byte(8'hA5, 1);
    send_byte(8'h11, 1);
    send_err();
    send_byte(8'hA5, 1);
    send_byte_err(8'h22);
    checkpoint("aborts");
    // errors and SYNC-as-data while hunting / mid-frame
    send_err();
    send_frame(8'hA5, 8'hA5, 8'hA5, 2);
    checkpoint("sync_data");

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      a = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      c = 8'hA5 ^ a ^ d;
      case ($urandom_range(0, 5))
        0, 1: send_frame(a, d, c, $urandom_range(1, 4));
        2:    send_frame(a, d, c ^ 8'h01, $urandom_range(1, 4));
        3:    send_byte($urandom_range(0, 255), $urandom_range(1, 3));
        4: begin
          send_byte(8'hA5, 1);
          if ($urandom_range(0, 1) == 1) send_byte(a, 1);
          send_err();
        end
        default: begin
          send_byte(8'hA5, 1);
          send_byte_err(a);
        end
      endcase
      if (i % 10 == 9) checkpoint("rand");
    end
    // flush any partial frame so the later phases start from HUNT
    if (frm.size() != 0) send_err();
    checkpoint("rand_end");

    // saturation
    for (int i = 0; i < 256; i++) send_frame(8'h00, 8'h00, 8'hFF, 1);
    checkpoint("sat");
    check("sat_ff", err_cnt, 8'hFF);
    send_frame(8'h00, 8'h00, 8'h00, 1);
    checkpoint("sat_more");

    // partial frame followed by long idle
    send_byte(8'hA5, 1);
    send_byte(8'h07, 1);
    tick(TMO > 1000 ? 150 : TMO + 10);
`ifdef UART_CMD_TIMEOUT_EN
    model_bad();
    checkpoint("timeout");
`else
    check("no_timeout_busy", busy, 1);
    send_byte(8'h08, 1);
    send_byte(8'hA5 ^ 8'h07 ^ 8'h08, 1);
    checkpoint("late_frame");
`endif

    // reset mid-frame
    send_byte(8'hA5, 1);
    send_byte(8'h07, 1);
    apply_reset("midframe");
    checkpoint("post_rst");
    send_frame(8'h3C, 8'hC3, 8'hA5 ^ 8'h3C ^ 8'hC3, 1);
    checkpoint("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
